chacha_keystream_xor: RTL
=========================

# chacha_keystream_xor

Consumer end of the ChaCha20 block engine (`PerformQround`). It captures each finished 4x4 block when `blockready` rises and applies the ChaCha20 feed-forward add against the original input state. It then serializes the 16 keystream words, XORs them with an incoming plaintext word stream through valid/ready handshakes, and requests the next block from the state loader when the current one is exhausted. It sits between the round engine and the AEAD datapath (ciphertext toward Poly1305).

## Interface
Parameters:
- `BLOCKS_W`, 4: width of `blocks_used`; matches the engine's `blocksproduced`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `blockready`  in  1  engine block-done level.
- `chachamatrixOUT`  in  word_t [3:0][3:0]  post-round state from engine.
- `chachamatrixIN`  in  word_t [3:0][3:0]  original input state; loader holds it stable until `next_block`.
- `pt_valid`  in  1  plaintext word valid.
- `pt_data`  in  32  plaintext word; bits [7:0] are the first byte.
- `pt_last`  in  1  final word of the message.
- `pt_ready`  out  1  plaintext word accepted this cycle when high with `pt_valid`.
- `ct_valid`  out  1  ciphertext word valid.
- `ct_data`  out  32  ciphertext word.
- `ct_last`  out  1  marks the ciphertext word derived from `pt_last`.
- `ct_ready`  in  1  downstream accepts.
- `next_block`  out  1  one-cycle pulse; loader increments the counter and restarts the engine.
- `blocks_used`  out  BLOCKS_W  blocks consumed since reset or last message end; wraps.
- `busy`  out  1  high in any state other than EMPTY.

## Operation
- Word mapping: keystream word k (0..15) = `chachamatrixOUT[3-k/4][3-k%4] + chachamatrixIN[3-k/4][3-k%4]`, computed mod 2^32. Example: word 0 is at [3][3] (constant 0x61707865 in the input).
- FSM:
  - EMPTY: if `blockready` is high and `blockready_q` (registered copy) is low, go to LOAD.
  - LOAD: register all 16 feed-forward sums into the keystream buffer; clear `idx`; go to STREAM.
  - STREAM: `pt_ready = !ct_valid || ct_ready`. On each pt handshake:
    - `ct_data <= pt_data ^ ks[idx]`, `ct_valid <= 1`, `ct_last <= pt_last`, `idx++`.
    - If `pt_last`: go to EMPTY, no `next_block`, clear `blocks_used`.
    - Else if `idx == 15`: go to EMPTY, pulse `next_block`, increment `blocks_used`.
- `ct_valid` clears on a `ct_ready` handshake unless a new word is loaded in the same cycle.
- A `blockready` rise outside EMPTY is ignored. The engine only produces after `next_block`, so a stale level is never recaptured; the edge detect enforces this.
- `pt_ready` is 0 in EMPTY and LOAD.
- Unused keystream words after `pt_last` are discarded.

## Timing
- Reset values: `pt_ready` 0, `ct_valid` 0, `ct_data` 0, `ct_last` 0, `next_block` 0, `blocks_used` 0, `busy` 0. FSM goes to EMPTY, `idx` 0, `blockready_q` 0, keystream buffer 0.
- `blockready` rise sampled at edge N → LOAD in cycle N+1 → STREAM from N+2; `pt_ready` can be high in the N+2 cycle.
- pt handshake at edge M → `ct_valid`/`ct_data` visible after M (1-cycle latency).
- With `ct_ready` held high, throughput is 1 word/cycle.
- `next_block` is high for exactly the cycle after the 16th handshake.
- If `ct_ready` is low while `ct_valid` is high: `pt_ready` is low and `ct_data` holds.
- Reset asserted mid-block: the block is lost and no `next_block` is issued. After release, the module waits for a fresh `blockready` rise.
- `pt_last` on word 15: treated as `pt_last` (no `next_block`).

## Structure
- `word_t`, the ARX state enum and the quarter-round index enum live in the shared chacha package, together with the constants `CHACHA_WORDS=16` and `SIGMA0..3`.
- A single sub-module, `chacha_ff_add`, is natural: a combinational 16-word feed-forward adder with flattened index mapping. The FSM, buffer and handshake logic stay in the top level.

## Test plan
- RFC 7539 §2.3.2 vector (key 00..1f, nonce 000000090000004a00000000, counter 1), rounds output driven, pt=0 x16, `ct_ready`=1 → ct words e4e7f110, 15593bd1, 1fdd0f50, c47120a3, …; `next_block` pulses once; `blocks_used`=1.
- Same block, pt=0xffffffff, `pt_last` on word 3 → 4 words; `ct_data[0]`=1b180eef; `ct_last` on the 4th word; no `next_block`; `blocks_used`=0.
- Backpressure: `ct_ready` toggles 1/0 every cycle → no word lost or duplicated; `ct_data` stable while stalled; 16 words out in 32 cycles.
- `blockready` held high through STREAM and re-pulsed mid-stream → no recapture; `idx` continues 0..15.
- `rst_n` low after word 7 → all outputs return to reset values immediately. After release plus a new `blockready` rise, streaming restarts at word 0.
- Three back-to-back blocks, 40-word message → `next_block` ×2, `blocks_used` ends at 0 (cleared by `pt_last`), 40 `ct_valid` handshakes.

Source files
------------

// File: rtl/chacha_keystream_xor_pkg.sv
// Shared ChaCha types and constants used by the round engine and its
// keystream consumer.
package chacha_keystream_xor_pkg;

  typedef logic [31:0] word_t;

  localparam int    CHACHA_WORDS = 16;
  localparam word_t SIGMA0 = 32'h6170_7865;
  localparam word_t SIGMA1 = 32'h3320_646e;
  localparam word_t SIGMA2 = 32'h7962_2d32;
  localparam word_t SIGMA3 = 32'h6b20_6574;

  // Round-engine sequencing, shared so both ends agree on encodings.
  typedef enum logic [2:0] {
    ARX_IDLE, ARX_ADD, ARX_XOR, ARX_ROT, ARX_DONE
  } arx_state_e;

  typedef enum logic [2:0] {
    QR_COL0, QR_COL1, QR_COL2, QR_COL3,
    QR_DIAG0, QR_DIAG1, QR_DIAG2, QR_DIAG3
  } qround_idx_e;

  typedef enum logic [1:0] {
    KS_EMPTY, KS_LOAD, KS_STREAM
  } ks_state_e;

  typedef word_t [CHACHA_WORDS-1:0] keystream_t;

endpackage

// File: rtl/chacha_ff_add.sv
// ChaCha20 feed-forward: keystream word k is post-round plus original state,
// with word 0 living at matrix position [3][3].
module chacha_ff_add
  import chacha_keystream_xor_pkg::*;
(
  input  word_t [3:0][3:0] i_state_out,
  input  word_t [3:0][3:0] i_state_in,
  output keystream_t       o_keystream
);

  for (genvar k = 0; k < CHACHA_WORDS; k++) begin : g_word
    assign o_keystream[k] = i_state_out[3 - k/4][3 - k%4]
                          + i_state_in[3 - k/4][3 - k%4];
  end

endmodule

// File: rtl/chacha_keystream_xor.sv
// Captures a finished ChaCha20 block, serializes its 16 keystream words and
// XORs them onto a valid/ready plaintext stream.
module chacha_keystream_xor
  import chacha_keystream_xor_pkg::*;
#(
  parameter int BLOCKS_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                blockready,
  input  word_t [3:0][3:0]    chachamatrixOUT,
  input  word_t [3:0][3:0]    chachamatrixIN,
  input  logic                pt_valid,
  input  logic [31:0]         pt_data,
  input  logic                pt_last,
  output logic                pt_ready,
  output logic                ct_valid,
  output logic [31:0]         ct_data,
  output logic                ct_last,
  input  logic                ct_ready,
  output logic                next_block,
  output logic [BLOCKS_W-1:0] blocks_used,
  output logic                busy
);

  ks_state_e           r_state, w_state_next;
  logic                r_blockready_q;
  keystream_t          r_ks;
  keystream_t          w_ks;
  logic [3:0]          r_idx;
  logic                r_ct_valid, r_ct_last, r_next_block;
  logic [31:0]         r_ct_data;
  logic [BLOCKS_W-1:0] r_blocks_used;
  logic                w_pt_ready, w_pt_fire, w_next_block_d;

  chacha_ff_add u_ff_add (
    .i_state_out (chachamatrixOUT),
    .i_state_in  (chachamatrixIN),
    .o_keystream (w_ks)
  );

  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= KS_EMPTY;
      r_blockready_q <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_blockready_q <= blockready;
    end
  end

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next   = r_state;
    w_pt_ready     = 1'b0;
    w_next_block_d = 1'b0;
    case (r_state)
      KS_EMPTY:  if (blockready && !r_blockready_q) w_state_next = KS_LOAD;
      KS_LOAD:   w_state_next = KS_STREAM;
      KS_STREAM: begin
        w_pt_ready = !r_ct_valid || ct_ready;
        if (pt_valid && w_pt_ready) begin
          if (pt_last) begin
            w_state_next = KS_EMPTY;
          end else if (r_idx == 4'd15) begin
            w_state_next   = KS_EMPTY;
            w_next_block_d = 1'b1;
          end
        end
      end
      default:   w_state_next = KS_EMPTY;
    endcase
  end

  assign w_pt_fire = pt_valid && w_pt_ready;

  // NOTE: the 16-word buffer is reset too, so no stale keystream survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_ks <= '0;
    else if (r_state == KS_LOAD) r_ks <= w_ks;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_ct_valid    <= 1'b0;
      r_ct_data     <= '0;
      r_ct_last     <= 1'b0;
      r_next_block  <= 1'b0;
      r_blocks_used <= '0;
    end else begin
      r_next_block <= w_next_block_d;
      if (r_state == KS_LOAD) r_idx <= '0;
      else if (w_pt_fire)     r_idx <= r_idx + 4'd1;

      // A fresh word wins over the downstream draining the current one.
      if (w_pt_fire) begin
        r_ct_data  <= pt_data ^ r_ks[r_idx];
        r_ct_valid <= 1'b1;
        r_ct_last  <= pt_last;
      end else if (ct_ready) begin
        r_ct_valid <= 1'b0;
      end

      if (w_pt_fire && pt_last) r_blocks_used <= '0;
      else if (w_next_block_d)  r_blocks_used <= r_blocks_used + BLOCKS_W'(1);
    end
  end

  assign pt_ready    = w_pt_ready;
  assign ct_valid    = r_ct_valid;
  assign ct_data     = r_ct_data;
  assign ct_last     = r_ct_last;
  assign next_block  = r_next_block;
  assign blocks_used = r_blocks_used;
  assign busy        = (r_state != KS_EMPTY);

endmodule
